muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle HI/LO arithmetic unit beside the EX stage: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU.
//  Replaces the single-cycle combinational multiply and adds iterative division and multiply-accumulate.
//  Holds the pipeline through stall_req_o and writes HI/LO once per accepted operation.
// PARAMETERS
//  DATA_W   32  operand width; HI/LO are DATA_W each, product is 2*DATA_W
//  MUL_LAT  3   multiply latency, in cycles from the accept edge to the done_o cycle; legal range >=1
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       reset, synchronous, active-low
//  start_i      in   1       request; accepted only in IDLE
//  annul_i      in   1       flush: abort the current op, no HI/LO write
//  op_i         in   3       operation code (muldiv_pkg::op_e)
//  src1_i       in   DATA_W  rs: multiplicand / dividend
//  src2_i       in   DATA_W  rt: multiplier / divisor
//  hi_i, lo_i   in   DATA_W  forwarded HI/LO, the accumulate base for MADD*/MSUB*
//  busy_o       out  1       state != IDLE
//  stall_req_o  out  1       combinational: (start_i & IDLE & !annul_i) | state in {MUL,DIV}
//  done_o       out  1       one-cycle pulse; hi_o/lo_o valid
//  hilo_we_o    out  1       equals done_o
//  hi_o, lo_o   out  DATA_W  result: product high/low, or remainder/quotient
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; busy_o, done_o, hilo_we_o=0; hi_o, lo_o=0; counters cleared.
//  Reset wins over every other input, including an op mid-flight.
//  FSM: IDLE -start_i&!annul_i-> MUL (mul ops) | DIV (div ops, divisor!=0) | DONE (div, divisor==0).
//   MUL counts MUL_LAT-1 cycles, then DONE.
//   DIV runs DATA_W restoring iterations, 1 quotient bit per cycle, then DONE.
//   DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE.
//  Latency: start edge T -> done_o high at T+MUL_LAT (mul) or T+DATA_W+1 (div); divide-by-zero -> T+1.
//  Operands, op and hi_i/lo_i are registered at accept; input changes afterwards have no effect.
//  Signed ops (MULT, MADD, MSUB, DIV): operate on magnitudes.
//   Product sign = src1 sign ^ src2 sign. Quotient sign = src1 sign ^ src2 sign.
//   Remainder takes the sign of the dividend.
//  DIV of the most-negative value by -1: lo=0x8000_0000, hi=0 (wraps, no trap).
//  Divide by zero (both kinds): lo=all-ones, hi=src1.
//  MADD*: {hi,lo} = {hi_i,lo_i} + product. MSUB*: {hi,lo} = {hi_i,lo_i} - product. Modulo 2^(2*DATA_W).
//  annul_i in MUL/DIV/DONE: next state IDLE. No done_o, no write. A done_o due in the same cycle is suppressed.
//  annul_i together with start_i in IDLE: start is not accepted.
//  start_i asserted while busy is neither queued nor lost; the EX stage holds it because stall_req_o is high.
//  hi_o/lo_o keep their last result between operations.
// STRUCTURE
//  muldiv_pkg:
//   op_e = MULT 0, MULTU 1, DIV 2, DIVU 3, MADD 4, MADDU 5, MSUB 6, MSUBU 7
//   state_e = IDLE, MUL, DIV, DONE
//   helpers is_signed(op), is_div(op)
//  Sub-module div_core: restoring divider.
//   Ports: clk, rst_n, load, kill, unsigned dividend/divisor, quot, rem, ready.
//   Iteration count is DATA_W.
//  Parent owns: FSM, sign fix-up, MUL_LAT shift pipeline for the product, accumulate adder.
// TESTING
//  1 MULT src1=0xFFFFFFFD src2=7 -> done_o at T+3, hi=0xFFFFFFFF lo=0xFFFFFFEB; stall_req_o high T..T+2.
//  2 DIVU 100/7 -> done_o at T+33, lo=14 hi=2. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0. DIVU 5/0 -> done_o at T+1, lo=0xFFFFFFFF hi=5.
//  4 MADDU hi_i=0 lo_i=0xFFFFFFFF, 1*1 -> hi=1 lo=0.
//    MSUB hi_i=0 lo_i=0, 1*1 -> hi=lo=0xFFFFFFFF.
//  5 Annul and restart:
//    DIVU issued, annul_i at iteration 10 -> no done_o, busy_o low next cycle.
//    Then MULTU 3*4 is accepted at once -> lo=12.
//  6 rst_n low during DIV iteration 5 -> all outputs 0 next cycle, no done_o.
//    start_i held high during an op -> exactly one done_o.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Operation codes, FSM states and decode helpers for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Signed variants occupy the even opcodes.
  function automatic logic is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_madd(input op_e op);
    return (op == MADD) || (op == MADDU);
  endfunction

  function automatic logic is_msub(input op_e op);
    return (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div.sv
// ============================================================================
// Module   : div_core
// Brief    : Unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              kill,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              ready
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic [DATA_W:0]   w_part;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  // The partial remainder is below 2*divisor, so the MSB of the difference is a clean borrow.
  assign w_part = {r_rem, r_q[DATA_W-1]};
  assign w_diff = w_part - {1'b0, r_d};
  assign w_ge   = ~w_diff[DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (kill) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (load) begin
      r_q    <= dividend;
      r_rem  <= '0;
      r_d    <= divisor;
      r_cnt  <= CNT_W'(DATA_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_q   <= {r_q[DATA_W-2:0], w_ge};
      r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_part[DATA_W-1:0];
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // High during the final iteration: quot/rem are valid from the next cycle on.
  assign ready = r_busy && (r_cnt == CNT_W'(1));
  assign quot  = r_q;
  assign rem   = r_rem;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle HI/LO unit: multiply, multiply-accumulate, divide.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              busy_o,
  output logic              stall_req_o,
  output logic              done_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  import muldiv_pkg::*;

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = (MUL_LAT > 2) ? CNT_W'(MUL_LAT - 2) : '0;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

  state_e            r_state, w_next;
  op_e               r_op;
  logic [DATA_W-1:0] r_a, r_b, r_hi, r_lo;
  logic [PROD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  op_e               w_op_in;
  logic              w_accept, w_done, w_sgn, w_neg, w_dz, w_div_last;
  logic [DATA_W-1:0] w_ma, w_mb, w_quot, w_rem, w_q_fix, w_r_fix;
  logic [PROD_W-1:0] w_prod, w_prod_q, w_mul_res, w_res;

  assign w_op_in  = op_e'(op_i);
  assign w_accept = start_i && !annul_i && (r_state == S_IDLE);

  // Product datapath works from the operands captured at accept.
  assign w_sgn  = is_signed(r_op);
  assign w_ma   = mag(r_a, w_sgn);
  assign w_mb   = mag(r_b, w_sgn);
  assign w_neg  = w_sgn && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
  assign w_prod = w_neg ? -({{DATA_W{1'b0}}, w_ma} * {{DATA_W{1'b0}}, w_mb})
                        :  ({{DATA_W{1'b0}}, w_ma} * {{DATA_W{1'b0}}, w_mb});

  generate
    if (MUL_LAT > 1) begin : g_pipe
      logic [PROD_W-1:0] r_pipe [MUL_LAT-1];
      always_ff @(posedge clk) begin
        r_pipe[0] <= w_prod;
        for (int i = 1; i < MUL_LAT - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
      assign w_prod_q = r_pipe[MUL_LAT-2];
    end else begin : g_nopipe
      assign w_prod_q = w_prod;
    end
  endgenerate

  assign w_mul_res = is_madd(r_op) ? (r_acc + w_prod_q) :
                     is_msub(r_op) ? (r_acc - w_prod_q) : w_prod_q;

  div_core #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_accept && is_div(w_op_in) && (src2_i != '0)),
    .kill     (annul_i),
    .dividend (mag(src1_i, is_signed(w_op_in))),
    .divisor  (mag(src2_i, is_signed(w_op_in))),
    .quot     (w_quot),
    .rem      (w_rem),
    .ready    (w_div_last)
  );

  // Remainder follows the dividend sign; the MIN/-1 quotient wraps naturally here.
  assign w_dz    = (r_b == '0);
  assign w_q_fix = w_neg ? -w_quot : w_quot;
  assign w_r_fix = (w_sgn && r_a[DATA_W-1]) ? -w_rem : w_rem;
  assign w_res   = !is_div(r_op) ? w_mul_res :
                   w_dz ? {r_a, {DATA_W{1'b1}}} : {w_r_fix, w_q_fix};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (is_div(w_op_in)) w_next = (src2_i == '0) ? S_DONE : S_DIV;
          else                 w_next = (MUL_LAT == 1) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        if (annul_i)                 w_next = S_IDLE;
        else if (r_cnt == '0)        w_next = S_DONE;
      end
      S_DIV: begin
        if (annul_i)                 w_next = S_IDLE;
        else if (w_div_last)         w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
        w_done = !annul_i;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= MULT;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op_in;
        r_a   <= src1_i;
        r_b   <= src2_i;
        r_acc <= {hi_i, lo_i};
        r_cnt <= MUL_CNT_INIT;
      end else if (r_state == S_MUL && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) begin
        r_hi <= w_res[PROD_W-1:DATA_W];
        r_lo <= w_res[DATA_W-1:0];
      end
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign stall_req_o = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o      = w_done;
  assign hilo_we_o   = w_done;
  assign hi_o        = w_done ? w_res[PROD_W-1:DATA_W] : r_hi;
  assign lo_o        = w_done ? w_res[DATA_W-1:0]      : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0, hi_i = '0, lo_i = '0;
  logic        busy_o, stall_req_o, done_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;

  muldiv_unit #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .hi_i(hi_i), .lo_i(lo_i),
    .busy_o(busy_o), .stall_req_o(stall_req_o), .done_o(done_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] res; int cyc; } exp_t;
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, h, l);
    logic [63:0] acc, sp, up;
    int sa, sb_, q, r;
    acc = {h, l};
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'h0, a} * {32'h0, b};
    sa  = a;
    sb_ = b;
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd4: return acc + sp;
      3'd5: return acc + up;
      3'd6: return acc - sp;
      3'd7: return acc - up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb_;
        r = sa % sb_;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (hilo_we_o !== done_o) check("hilo_we_eq_done", {63'b0, hilo_we_o}, {63'b0, done_o});
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("hi", {32'h0, hi_o}, {32'h0, e.res[63:32]});
        check("lo", {32'h0, lo_o}, {32'h0, e.res[31:0]});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Caller is positioned just after a rising edge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, h, l, input bit hold);
    exp_t e;
    int   lat;
    bit   seen;
    lat   = (op == 3'd2 || op == 3'd3) ? ((b == 0) ? 1 : 33) : MUL_LAT;
    e.res = model(op, a, b, h, l);
    e.cyc = cyc + lat;
    sb.push_back(e);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; hi_i = h; lo_i = l;
    #1 check("stall_on_start", {63'b0, stall_req_o}, 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else if (k >= 1) begin
        check("stall_while_busy", {63'b0, stall_req_o}, 64'd1);
        if (!hold) begin
          start_i = 1'b0;
          op_i = 3'($urandom); src1_i = $urandom; src2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
        end
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else       check("stall_in_done", {63'b0, stall_req_o}, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("busy_after_done", {63'b0, busy_o}, 64'd0);
    check("hilo_hold", {hi_o, lo_o}, e.res);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, busy_o}, 64'd0);
    check("reset_done", {63'b0, done_o}, 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    run_op(3'd3, 32'd5, 32'd0, 32'h0, 32'h0, 1'b0);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, 32'h0, 32'h0, 1'b1);
    run_op(3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd1, 32'd1, 32'h0, 32'h0, 1'b1);

    // Annul a divide mid-flight, then accept a new op straight away.
    start_i = 1'b1; op_i = 3'd3; src1_i = 32'd1000; src2_i = 32'd3;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    check("busy_after_annul", {63'b0, busy_o}, 64'd0);
    run_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0);

    // Start together with annul must not be accepted.
    start_i = 1'b1; annul_i = 1'b1; op_i = 3'd1;
    #1 check("stall_start_annul", {63'b0, stall_req_o}, 64'd0);
    @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
    check("busy_start_annul", {63'b0, busy_o}, 64'd0);

    // Reset in the middle of a divide.
    start_i = 1'b1; op_i = 3'd2; src1_i = 32'hFFFF_FC18; src2_i = 32'd7;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", {63'b0, busy_o}, 64'd0);
    check("rst_stall", {63'b0, stall_req_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_done", {63'b0, done_o}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
